// File: rtl/l1_bus_pkg.sv
// l1_bus_pkg: shared widths and grant/state encodings for the L1-to-MMU bus
package l1_bus_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} grant_t;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;
endpackage

// File: rtl/l1_rr_pick.sv
// l1_rr_pick: two-way round-robin chooser, a tie goes to the port opposite last_grant
module l1_rr_pick
  import l1_bus_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant
);
  // tie-break against the previous winner, otherwise the lone requester wins
  always_comb grant = (req_i && req_d) ? ((last_grant == GNT_I) ? GNT_D : GNT_I) :
                      req_i ? GNT_I : req_d ? GNT_D : GNT_NONE;
endmodule

// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter: shares the l1mmu refill/writeback port between the I and D caches
module l1_mmu_arbiter
  import l1_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_req_read,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0] i_write_data,
  output logic              i_read_done,
  output logic              i_write_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_read_done,
  output logic              d_write_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_read_done,
  input  logic              mmu_write_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              busy,
  output logic [CNT_W-1:0]  i_txn_cnt,
  output logic [CNT_W-1:0]  d_txn_cnt
);
  state_t state, state_nx;
  grant_t last_grant, pick;
  logic   gi, gd, finish, take;
  l1_rr_pick u_pick (
    .req_i     (i_req_read | i_req_write),
    .req_d     (d_req_read | d_req_write),
    .last_grant(last_grant),
    .grant     (pick)
  );
  assign gi     = state == GRANT_I;
  assign gd     = state == GRANT_D;
  assign busy   = gi | gd;
  assign finish = busy & (mmu_read_done | mmu_write_done);
  assign take   = (state == IDLE) & (pick != GNT_NONE);
  // grant from IDLE via the picker, return to IDLE on any MMU done
  always_comb state_nx = (state == IDLE) ? ((pick == GNT_I) ? GRANT_I : (pick == GNT_D) ? GRANT_D : IDLE) :
                         finish ? IDLE : state;
  // state register
  always_ff @(posedge sys_clk) state <= rst ? IDLE : state_nx;
  // capture the winner's request, clear on completion so IDLE drives zeros; write beats read
  always_ff @(posedge sys_clk)
    if (rst || finish) begin
      mmu_req_read   <= 1'b0;
      mmu_req_write  <= 1'b0;
      mmu_req_addr   <= '0;
      mmu_write_data <= '0;
    end else if (take) begin
      mmu_req_write  <= (pick == GNT_I) ? i_req_write : d_req_write;
      mmu_req_read   <= (pick == GNT_I) ? i_req_read & ~i_req_write : d_req_read & ~d_req_write;
      mmu_req_addr   <= (pick == GNT_I) ? i_req_addr : d_req_addr;
      mmu_write_data <= (pick == GNT_I) ? i_write_data : d_write_data;
    end
  // remember the finished grant for round-robin and count completions
  always_ff @(posedge sys_clk)
    if (rst) begin
      last_grant <= GNT_I;
      i_txn_cnt  <= '0;
      d_txn_cnt  <= '0;
    end else if (finish) begin
      last_grant <= gi ? GNT_I : GNT_D;
      i_txn_cnt  <= i_txn_cnt + CNT_W'(gi);
      d_txn_cnt  <= d_txn_cnt + CNT_W'(gd);
    end
  assign i_read_done  = mmu_read_done & gi;
  assign i_write_done = mmu_write_done & gi;
  assign i_read_data  = gi ? mmu_read_data : '0;
  assign d_read_done  = mmu_read_done & gd;
  assign d_write_done = mmu_write_done & gd;
  assign d_read_data  = gd ? mmu_read_data : '0;
endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// tb_l1_mmu_arbiter: directed self-checking bench for l1_mmu_arbiter
module tb_l1_mmu_arbiter;
  logic         sys_clk = 1'b0;
  logic         rst;
  logic         i_req_read, i_req_write, d_req_read, d_req_write;
  logic [31:0]  i_req_addr, d_req_addr, mmu_req_addr;
  logic [255:0] i_write_data, d_write_data, i_read_data, d_read_data, mmu_write_data, mmu_read_data;
  logic         i_read_done, i_write_done, d_read_done, d_write_done;
  logic         mmu_req_read, mmu_req_write, mmu_read_done, mmu_write_done, busy;
  logic [15:0]  i_txn_cnt, d_txn_cnt;
  int n_assert = 0;
  int n_fail = 0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] P5A = {32{8'h5A}};
  l1_mmu_arbiter dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_req_read(i_req_read), .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_write_data(i_write_data),
    .i_read_done(i_read_done), .i_write_done(i_write_done), .i_read_data(i_read_data),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr), .d_write_data(d_write_data),
    .d_read_done(d_read_done), .d_write_done(d_write_done), .d_read_data(d_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write), .mmu_req_addr(mmu_req_addr),
    .mmu_write_data(mmu_write_data), .mmu_read_done(mmu_read_done), .mmu_write_done(mmu_write_done),
    .mmu_read_data(mmu_read_data), .busy(busy), .i_txn_cnt(i_txn_cnt), .d_txn_cnt(d_txn_cnt)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nclk();
    @(negedge sys_clk);
  endtask
  initial begin
    rst = 1'b1;
    {i_req_read, i_req_write, d_req_read, d_req_write} = '0;
    i_req_addr = '0; d_req_addr = '0; i_write_data = '0; d_write_data = '0;
    mmu_read_done = 1'b0; mmu_write_done = 1'b0; mmu_read_data = '0;
    repeat (2) nclk();
    rst = 1'b0;
    nclk();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_req", 256'({mmu_req_read, mmu_req_write}), 256'(0));
    chk("rst_addr", 256'(mmu_req_addr), 256'(0));
    chk("rst_wdata", mmu_write_data, 256'(0));
    chk("rst_done", 256'({i_read_done, i_write_done, d_read_done, d_write_done}), 256'(0));
    chk("rst_icnt", 256'(i_txn_cnt), 256'(0));
    chk("rst_dcnt", 256'(d_txn_cnt), 256'(0));
    for (int k = 0; k < 10; k++) begin
      nclk();
      chk("idle_req", 256'({mmu_req_read, mmu_req_write, busy}), 256'(0));
    end
    i_req_read = 1'b1; i_req_addr = 32'h2000_000C;
    nclk();
    chk("i_busy", 256'(busy), 256'(1));
    chk("i_req_rd", 256'({mmu_req_read, mmu_req_write}), 256'(2));
    chk("i_addr", 256'(mmu_req_addr), 256'(32'h2000_000C));
    repeat (3) nclk();
    chk("i_hold", 256'({mmu_req_read, mmu_req_addr}), {223'd0, 1'b1, 32'h2000_000C});
    mmu_read_done = 1'b1; mmu_read_data = A5; #1;
    chk("i_rdone", 256'(i_read_done), 256'(1));
    chk("i_rdata", i_read_data, A5);
    chk("i_d_nodone", 256'(d_read_done), 256'(0));
    chk("i_d_nodata", d_read_data, 256'(0));
    nclk();
    mmu_read_done = 1'b0; i_req_read = 1'b0; #1;
    chk("i_pulse", 256'(i_read_done), 256'(0));
    chk("i_after_busy", 256'({busy, mmu_req_read}), 256'(0));
    chk("i_cnt1", 256'(i_txn_cnt), 256'(1));
    rst = 1'b1;
    nclk();
    rst = 1'b0;
    i_req_read = 1'b1; i_req_addr = 32'h1000;
    d_req_write = 1'b1; d_req_addr = 32'h4000; d_write_data = 256'hEEEEFFFF;
    nclk();
    chk("tie_d_req", 256'({mmu_req_read, mmu_req_write}), 256'(1));
    chk("tie_d_addr", 256'(mmu_req_addr), 256'(32'h4000));
    chk("tie_d_wdata", mmu_write_data, 256'hEEEEFFFF);
    mmu_write_done = 1'b1; #1;
    chk("tie_d_wdone", 256'({d_write_done, i_write_done}), 256'(2));
    nclk();
    mmu_write_done = 1'b0; d_req_write = 1'b0; #1;
    chk("tie_idle", 256'({busy, mmu_req_write, mmu_req_read}), 256'(0));
    chk("tie_dcnt", 256'(d_txn_cnt), 256'(1));
    nclk();
    chk("tie_i_req", 256'({busy, mmu_req_read, mmu_req_write}), 256'(6));
    chk("tie_i_addr", 256'(mmu_req_addr), 256'(32'h1000));
    mmu_read_done = 1'b1; mmu_read_data = P5A; #1;
    chk("tie_i_rdone", 256'({i_read_done, d_read_done}), 256'(2));
    chk("tie_i_rdata", i_read_data, P5A);
    nclk();
    mmu_read_done = 1'b0; i_req_read = 1'b0; #1;
    chk("tie_icnt", 256'(i_txn_cnt), 256'(1));
    chk("tie_dcnt2", 256'(d_txn_cnt), 256'(1));
    i_req_read = 1'b1; d_req_read = 1'b1;
    for (int t = 0; t < 6; t++) begin
      nclk();
      chk("alt_busy", 256'(busy), 256'(1));
      chk("alt_addr", 256'(mmu_req_addr), 256'((t % 2 == 0) ? 32'h4000 : 32'h1000));
      mmu_read_done = 1'b1; mmu_read_data = 256'(t + 1); #1;
      chk("alt_d_done", 256'(d_read_done), 256'(t % 2 == 0));
      chk("alt_i_done", 256'(i_read_done), 256'(t % 2 != 0));
      nclk();
      mmu_read_done = 1'b0;
      if (t == 5) begin
        i_req_read = 1'b0; d_req_read = 1'b0;
      end
      chk("alt_gap", 256'(busy), 256'(0));
    end
    chk("alt_icnt", 256'(i_txn_cnt), 256'(4));
    chk("alt_dcnt", 256'(d_txn_cnt), 256'(4));
    d_req_read = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h3000_000C; d_write_data = 256'h1234;
    nclk();
    chk("rw_req", 256'({mmu_req_read, mmu_req_write}), 256'(1));
    chk("rw_addr", 256'(mmu_req_addr), 256'(32'h3000_000C));
    mmu_write_done = 1'b1; #1;
    chk("rw_wdone", 256'({d_write_done, d_read_done}), 256'(2));
    nclk();
    mmu_write_done = 1'b0; d_req_write = 1'b0;
    chk("rw_gap", 256'(busy), 256'(0));
    chk("rw_dcnt", 256'(d_txn_cnt), 256'(5));
    nclk();
    chk("rw_reread", 256'({mmu_req_read, mmu_req_write}), 256'(2));
    mmu_read_done = 1'b1; mmu_read_data = A5; #1;
    chk("rw_rdone", 256'({d_read_done, d_write_done}), 256'(2));
    chk("rw_rdata", d_read_data, A5);
    nclk();
    mmu_read_done = 1'b0; d_req_read = 1'b0;
    chk("rw_dcnt2", 256'(d_txn_cnt), 256'(6));
    i_req_read = 1'b1; i_req_addr = 32'h2000;
    nclk();
    chk("mid_busy", 256'(busy), 256'(1));
    nclk();
    rst = 1'b1; i_req_read = 1'b0;
    nclk();
    rst = 1'b0;
    chk("mid_req", 256'({busy, mmu_req_read, mmu_req_write}), 256'(0));
    chk("mid_addr", 256'(mmu_req_addr), 256'(0));
    chk("mid_cnt", 256'({i_txn_cnt, d_txn_cnt}), 256'(0));
    d_req_read = 1'b1; d_req_addr = 32'h8000;
    nclk();
    chk("post_d_req", 256'({busy, mmu_req_read}), 256'(3));
    chk("post_d_addr", 256'(mmu_req_addr), 256'(32'h8000));
    mmu_read_done = 1'b1; mmu_read_data = P5A; #1;
    chk("post_d_done", 256'({d_read_done, i_read_done}), 256'(2));
    nclk();
    mmu_read_done = 1'b0; d_req_read = 1'b0;
    chk("post_dcnt", 256'(d_txn_cnt), 256'(1));
    nclk();
    mmu_read_done = 1'b1; mmu_read_data = A5; #1;
    chk("spur_done", 256'({i_read_done, d_read_done, i_write_done, d_write_done}), 256'(0));
    chk("spur_idata", i_read_data, 256'(0));
    chk("spur_ddata", d_read_data, 256'(0));
    nclk();
    mmu_read_done = 1'b0;
    chk("spur_cnt", 256'({i_txn_cnt, d_txn_cnt}), 256'(1));
    chk("spur_busy", 256'(busy), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
